gnrl_dbnc: RTL and testbench

Per-bit glitch filter and edge detector. It consumes level signals that have already been brought into the i_clk domain, such as the output of a two-flop synchronizer, or raw pins when the built-in synchronizer is compiled in. For each bit it produces a debounced level and one-cycle rise and fall pulses. Typical users are fault inputs, enable pins and mode straps that feed control FSMs in the power stage.

---
 rtl/gnrl_dbnc.sv | 93 +++++++++
 tb/tb_gnrl_dbnc.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnrl_dbnc.sv
// Per-bit glitch filter with registered debounced level and one-cycle rise/fall pulses.
// Optional 2-stage input synchronizer compiled in with `define GNRL_DBNC_SYNC_EN.
module gnrl_dbnc #(
    parameter int            DW      = 8,
    parameter int            CNT_W   = 8,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [DW-1:0]    i_data,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_filt_cnt,
    output logic [DW-1:0]    o_data,
    output logic [DW-1:0]    o_rise,
    output logic [DW-1:0]    o_fall
);

    logic [DW-1:0] filt_in;

`ifdef GNRL_DBNC_SYNC_EN
    logic [DW-1:0] sync1_reg;
    logic [DW-1:0] sync2_reg;

    // Sync flops reset to RST_VAL so a quiet input produces no spurious count after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_reg <= RST_VAL;
            sync2_reg <= RST_VAL;
        end else begin
            sync1_reg <= i_data;
            sync2_reg <= sync1_reg;
        end
    end

    assign filt_in = sync2_reg;
`else
    assign filt_in = i_data;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_bit
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             data_reg;
            logic             data_next;
            logic             rise_reg;
            logic             rise_next;
            logic             fall_reg;
            logic             fall_next;
            logic             mismatch;

            assign mismatch = filt_in[gi] ^ data_reg;

            // The >= compare caps the counter at the threshold, so it never wraps
            // and a lowered threshold takes effect on the very next mismatch.
            always_comb begin
                data_next = data_reg;
                cnt_next  = '0;
                rise_next = 1'b0;
                fall_next = 1'b0;
                if (i_en && mismatch) begin
                    if (cnt_reg >= i_filt_cnt) begin
                        data_next = ~data_reg;
                        rise_next = ~data_reg;
                        fall_next = data_reg;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    cnt_reg  <= '0;
                    data_reg <= RST_VAL[gi];
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_next;
                    data_reg <= data_next;
                    rise_reg <= rise_next;
                    fall_reg <= fall_next;
                end
            end

            assign o_data[gi] = data_reg;
            assign o_rise[gi] = rise_reg;
            assign o_fall[gi] = fall_reg;
        end
    endgenerate

endmodule

// File: tb/tb_gnrl_dbnc.sv
// Self-checking bench for gnrl_dbnc: directed scenarios plus randomized traffic
// compared against a run-length reference model.
module tb_gnrl_dbnc;

    localparam int DW = 8;
    localparam int CNT_W = 8;
    localparam logic [DW-1:0] RST_VAL = 8'h00;
`ifdef GNRL_DBNC_SYNC_EN
    localparam int SX = 2;
`else
    localparam int SX = 0;
`endif

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic [DW-1:0]    i_data = '0;
    logic             i_en = 1'b1;
    logic [CNT_W-1:0] i_filt_cnt = 8'd3;
    logic [DW-1:0]    o_data;
    logic [DW-1:0]    o_rise;
    logic [DW-1:0]    o_fall;

    int errors = 0;
    int checks = 0;

    // Reference model: a bit follows its input once it has seen more than N
    // consecutive enabled samples that differ from the current output.
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_rise;
    logic [DW-1:0] m_fall;
    logic [DW-1:0] m_s1;
    logic [DW-1:0] m_s2;
    int            m_run [DW];

    gnrl_dbnc #(.DW(DW), .CNT_W(CNT_W), .RST_VAL(RST_VAL)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_data     (i_data),
        .i_en       (i_en),
        .i_filt_cnt (i_filt_cnt),
        .o_data     (o_data),
        .o_rise     (o_rise),
        .o_fall     (o_fall)
    );

    always #5 i_clk = ~i_clk;

    task automatic model_reset();
        m_data = RST_VAL;
        m_rise = '0;
        m_fall = '0;
        m_s1   = RST_VAL;
        m_s2   = RST_VAL;
        for (int k = 0; k < DW; k++) m_run[k] = 0;
    endtask

    // Advance one clock edge, update the model with the inputs seen at that edge.
    task automatic tick();
        logic [DW-1:0] smp;
        @(posedge i_clk);
        if (!i_rst_n) begin
            model_reset();
        end else begin
            if (SX != 0) begin
                smp  = m_s2;
                m_s2 = m_s1;
                m_s1 = i_data;
            end else begin
                smp = i_data;
            end
            m_rise = '0;
            m_fall = '0;
            for (int k = 0; k < DW; k++) begin
                if (i_en && (smp[k] != m_data[k])) begin
                    m_run[k]++;
                    if (m_run[k] > int'(i_filt_cnt)) begin
                        m_data[k] = ~m_data[k];
                        m_rise[k] = m_data[k];
                        m_fall[k] = ~m_data[k];
                        m_run[k]  = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic reset_dut();
        i_data     = RST_VAL;
        i_rst_n    = 1'b0;
        #2;
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_filt_cnt = 8'd3;
        i_en       = 1'b1;
        reset_dut();
        checks++;
        if ({o_data, o_rise, o_fall} !== {RST_VAL, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: got data=%h rise=%h fall=%h, need %h/00/00", o_data, o_rise, o_fall, RST_VAL);
        end
        for (int e = 1; e <= 20; e++) begin
            tick();
            checks++;
            if ({o_data, o_rise, o_fall} !== {8'h00, 8'h00, 8'h00}) begin
                errors++;
                $display("FAIL reset_quiet edge %0d: got data=%h rise=%h fall=%h, need 00/00/00", e, o_data, o_rise, o_fall);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_rise();
        reset_dut();
        i_filt_cnt = 8'd3;
        i_data     = 8'h01;
        for (int e = 1; e <= 6 + SX; e++) begin
            tick();
            checks++;
            if ({o_data, o_rise, o_fall} !== {m_data, m_rise, m_fall}) begin
                errors++;
                $display("FAIL rise_model edge %0d: got %h/%h/%h, need %h/%h/%h", e, o_data, o_rise, o_fall, m_data, m_rise, m_fall);
            end
            checks++;
            if ({o_data[0], o_rise[0]} !== {(e >= 4 + SX), (e == 4 + SX)}) begin
                errors++;
                $display("FAIL rise_bit0 edge %0d: got data=%b rise=%b, need %b/%b", e, o_data[0], o_rise[0], (e >= 4 + SX), (e == 4 + SX));
            end
        end
        $display("test_rise done");
    endtask

    task automatic test_glitch();
        reset_dut();
        i_filt_cnt = 8'd3;
        // 3-cycle pulse is rejected, then a 4-cycle pulse passes through.
        for (int e = 1; e <= 10 + SX; e++) begin
            i_data = (e <= 3) ? 8'h02 : 8'h00;
            tick();
            checks++;
            if ({o_data[1], o_rise[1], o_fall[1]} !== 3'b000) begin
                errors++;
                $display("FAIL glitch_reject edge %0d: got data=%b rise=%b fall=%b, need 0/0/0", e, o_data[1], o_rise[1], o_fall[1]);
            end
        end
        for (int e = 1; e <= 12 + SX; e++) begin
            i_data = (e <= 4) ? 8'h02 : 8'h00;
            tick();
            checks++;
            if ({o_rise[1], o_fall[1]} !== {(e == 4 + SX), (e == 8 + SX)}) begin
                errors++;
                $display("FAIL glitch_pass edge %0d: got rise=%b fall=%b, need %b/%b", e, o_rise[1], o_fall[1], (e == 4 + SX), (e == 8 + SX));
            end
            checks++;
            if ({o_data, o_rise, o_fall} !== {m_data, m_rise, m_fall}) begin
                errors++;
                $display("FAIL glitch_model edge %0d: got %h/%h/%h, need %h/%h/%h", e, o_data, o_rise, o_fall, m_data, m_rise, m_fall);
            end
        end
        $display("test_glitch done");
    endtask

    task automatic test_n0();
        logic prev = 1'b0;
        reset_dut();
        i_filt_cnt = 8'd0;
        for (int e = 1; e <= 12; e++) begin
            i_data[2] = ~i_data[2];
            tick();
            checks++;
            if ({o_data, o_rise, o_fall} !== {m_data, m_rise, m_fall}) begin
                errors++;
                $display("FAIL n0_model edge %0d: got %h/%h/%h, need %h/%h/%h", e, o_data, o_rise, o_fall, m_data, m_rise, m_fall);
            end
            if (e > SX) begin
                checks++;
                if ({o_rise[2], o_fall[2]} !== {~prev, prev}) begin
                    errors++;
                    $display("FAIL n0_alternate edge %0d: got rise=%b fall=%b, need %b/%b", e, o_rise[2], o_fall[2], ~prev, prev);
                end
                prev = ~prev;
            end
        end
        $display("test_n0 done");
    endtask

    task automatic test_threshold();
        reset_dut();
        i_filt_cnt = 8'hFF;
        i_data     = 8'h08;
        for (int e = 1; e <= 300; e++) begin
            tick();
            checks++;
            if ({o_data[3], o_rise[3]} !== {(e >= 256 + SX), (e == 256 + SX)}) begin
                errors++;
                $display("FAIL max_n edge %0d: got data=%b rise=%b, need %b/%b", e, o_data[3], o_rise[3], (e >= 256 + SX), (e == 256 + SX));
            end
        end
        reset_dut();
        i_filt_cnt = 8'd10;
        i_data     = 8'h10;
        for (int e = 1; e <= 5 + SX; e++) tick();
        checks++;
        if (o_data[4] !== 1'b0) begin
            errors++;
            $display("FAIL lower_n_early: got data=%b, need 0", o_data[4]);
        end
        i_filt_cnt = 8'd2;
        tick();
        checks++;
        if ({o_data[4], o_rise[4]} !== 2'b11) begin
            errors++;
            $display("FAIL lower_n_flip: got data=%b rise=%b, need 1/1", o_data[4], o_rise[4]);
        end
        $display("test_threshold done");
    endtask

    task automatic test_enable();
        reset_dut();
        i_filt_cnt = 8'd5;
        i_data     = 8'h20;
        for (int e = 1; e <= 2 + SX; e++) tick();
        i_en = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if ({o_data, o_rise, o_fall} !== 24'h0) begin
                errors++;
                $display("FAIL disabled edge %0d: got %h/%h/%h, need 00/00/00", e, o_data, o_rise, o_fall);
            end
        end
        i_en = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if ({o_data[5], o_rise[5]} !== {(e >= 6), (e == 6)}) begin
                errors++;
                $display("FAIL reenable edge %0d: got data=%b rise=%b, need %b/%b", e, o_data[5], o_rise[5], (e >= 6), (e == 6));
            end
        end
        $display("test_enable done");
    endtask

    task automatic test_reset_mid();
        reset_dut();
        i_filt_cnt = 8'd5;
        i_data     = 8'h40;
        for (int e = 1; e <= 3 + SX; e++) tick();
        i_rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({o_data, o_rise, o_fall} !== {RST_VAL, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid: got %h/%h/%h, need %h/00/00", o_data, o_rise, o_fall, RST_VAL);
        end
        tick();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int e = 1; e <= 10 + SX; e++) begin
            tick();
            checks++;
            if ({o_data, o_rise, o_fall} !== {m_data, m_rise, m_fall}) begin
                errors++;
                $display("FAIL after_reset edge %0d: got %h/%h/%h, need %h/%h/%h", e, o_data, o_rise, o_fall, m_data, m_rise, m_fall);
            end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        reset_dut();
        i_filt_cnt = 8'd2;
        for (int e = 1; e <= 3000; e++) begin
            for (int k = 0; k < DW; k++)
                if ($urandom_range(0, 5) == 0) i_data[k] = ~i_data[k];
            if ($urandom_range(0, 49) == 0) i_filt_cnt = CNT_W'($urandom_range(0, 4));
            i_en = ($urandom_range(0, 19) != 0);
            tick();
            checks++;
            if ({o_data, o_rise, o_fall} !== {m_data, m_rise, m_fall}) begin
                errors++;
                $display("FAIL random edge %0d: got %h/%h/%h, need %h/%h/%h", e, o_data, o_rise, o_fall, m_data, m_rise, m_fall);
            end
        end
        i_en = 1'b1;
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rise();
        test_glitch();
        test_n0();
        test_threshold();
        test_enable();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
